// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp - parametrised multi-port register file for the MIPS datapath.
//
// Two write ports with per-byte enables, NUM_RD combinational read ports,
// optional same-cycle write-to-read bypass, optional hardwired-zero register 0
// and a synchronous clear of the whole array.
//
// Interface timing: there is no handshake. Every write presented with weN=1
// is accepted at the next rising edge, and every read is a purely
// combinational function of raddr, the stored array and (with BYPASS=1) the
// write ports of the current cycle.
//
// Parameters
//   DATA_W   register width in bits (multiple of 8)
//   ADDR_W   address width; the array holds 2**ADDR_W registers
//   NUM_RD   number of read ports (1..8)
//   BYPASS   1: reads return the value the register will hold after the edge
//   ZERO_REG 1: register 0 reads as 0 and ignores writes
//
// Ports
//   clk                 clock, rising edge
//   rst                 synchronous active-high clear of every register
//   we0/waddr0/wdata0/wbe0  write port 0 (enable, address, data, byte enables)
//   we1/waddr1/wdata1/wbe1  write port 1, wins over port 0 on a shared lane
//   raddr               NUM_RD flattened read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata               NUM_RD flattened read data,      port k at [k*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic [DATA_W/8-1:0]        wbe0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [DATA_W/8-1:0]        wbe1,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] r_mem  [DEPTH];
  // w_next[i] is the value register i will hold after this edge if rst is low.
  // The same array feeds both the write path and the bypass read path, so the
  // bypassed value can never disagree with what actually gets stored.
  logic [DATA_W-1:0] w_next [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i] = r_mem[i];
      for (int b = 0; b < NB; b++) begin
        // Per-lane merge: port 1 owns any lane it enables, port 0 fills the
        // lanes only it enables, untouched lanes keep the stored byte.
        if (we1 && (waddr1 == ADDR_W'(i)) && wbe1[b]) begin
          w_next[i][8*b +: 8] = wdata1[8*b +: 8];
        end else if (we0 && (waddr0 == ADDR_W'(i)) && wbe0[b]) begin
          w_next[i][8*b +: 8] = wdata0[8*b +: 8];
        end
      end
    end
    // Register 0 never takes a write, so it stays at its cleared value.
    if (ZERO_REG != 0) begin
      w_next[0] = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        r_mem[i] <= '0;
      end else begin
        r_mem[i] <= w_next[i];
      end
    end
  end

  // Read ports: reset forces zero without bypass, address 0 is forced to zero
  // when hardwired, otherwise the stored or next-state value is selected.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = raddr[k*ADDR_W +: ADDR_W];
    assign w_rd = (BYPASS != 0) ? w_next[w_ra] : r_mem[w_ra];

    assign rdata[k*DATA_W +: DATA_W] =
      (rst || ((ZERO_REG != 0) && (w_ra == '0))) ? '0 : w_rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp - self-checking bench for regfile_mp.
//
// Three instances share one stimulus stream:
//   u_a : 32-bit, 32 regs, 2 read ports, BYPASS=1, ZERO_REG=1
//   u_b : 32-bit, 32 regs, 2 read ports, BYPASS=0, ZERO_REG=0
//   u_w : 64-bit, 16 regs, 4 read ports, BYPASS=1, ZERO_REG=1
// The driver computes expected read data from a reference model (plain
// arrays updated with byte-lane overwrites, port 1 applied last) and pushes
// them into exp_q; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [63:0] wd0, wd1;
  logic [7:0]  be0, be1;
  logic [4:0]  ra0, ra1;
  logic [3:0]  rw [4];
  logic [63:0] rd_a, rd_b;
  logic [255:0] rd_w;
  logic        prev_rst;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(wa0), .wdata0(wd0[31:0]), .wbe0(be0[3:0]),
    .we1(we1), .waddr1(wa1), .wdata1(wd1[31:0]), .wbe1(be1[3:0]),
    .raddr({ra1, ra0}), .rdata(rd_a)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(wa0), .wdata0(wd0[31:0]), .wbe0(be0[3:0]),
    .we1(we1), .waddr1(wa1), .wdata1(wd1[31:0]), .wbe1(be1[3:0]),
    .raddr({ra1, ra0}), .rdata(rd_b)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) u_w (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(wa0[3:0]), .wdata0(wd0), .wbe0(be0),
    .we1(we1), .waddr1(wa1[3:0]), .wdata1(wd1), .wbe1(be1),
    .raddr({rw[3], rw[2], rw[1], rw[0]}), .rdata(rd_w)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int          inst;
    int          port;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [63:0] actual(input int inst, input int port);
    case (inst)
      0:       return {32'h0, rd_a[port*32 +: 32]};
      1:       return {32'h0, rd_b[port*32 +: 32]};
      default: return rd_w[port*64 +: 64];
    endcase
  endfunction

  exp_t        mon_e;
  logic [63:0] mon_act;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = actual(mon_e.inst, mon_e.port);
      checks++;
      if (mon_act !== mon_e.val) begin
        failures++;
        $display("FAIL %s inst=%0d port=%0d got=%h exp=%h t=%0t",
                 mon_e.name, mon_e.inst, mon_e.port, mon_act, mon_e.val, $time);
      end
    end
  end

  task automatic push_lit(input int inst, input int port, input logic [63:0] val,
                          input string name);
    exp_t e;
    e.inst = inst; e.port = port; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_a [32];
  logic [31:0] m_b [32];
  logic [63:0] m_w [16];

  // Value of a register after the edge: start from the old value, overwrite
  // the lanes port 0 enables, then the lanes port 1 enables (port 1 wins).
  function automatic logic [63:0] after_edge(input logic [63:0] old, input int a,
                                             input int nb, input int amask);
    logic [63:0] v;
    v = old;
    if (we0 && ((int'(wa0) & amask) == a))
      for (int b = 0; b < nb; b++) if (be0[b]) v[8*b +: 8] = wd0[8*b +: 8];
    if (we1 && ((int'(wa1) & amask) == a))
      for (int b = 0; b < nb; b++) if (be1[b]) v[8*b +: 8] = wd1[8*b +: 8];
    return v;
  endfunction

  task automatic push_model();
    logic [63:0] v;
    int a;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? int'(ra0) : int'(ra1);
      v = after_edge({32'h0, m_a[a]}, a, 4, 31) & 64'hFFFF_FFFF;
      if (rst || a == 0) v = '0;
      push_lit(0, k, v, "model_a");
      v = rst ? 64'h0 : {32'h0, m_b[a]};
      push_lit(1, k, v, "model_b");
    end
    for (int k = 0; k < 4; k++) begin
      a = int'(rw[k]);
      v = after_edge(m_w[a], a, 8, 15);
      if (rst || a == 0) v = '0;
      push_lit(2, k, v, "model_w");
    end
  endtask

  task automatic update_model();
    logic [63:0] v;
    if (rst) begin
      for (int a = 0; a < 32; a++) begin m_a[a] = '0; m_b[a] = '0; end
      for (int a = 0; a < 16; a++) m_w[a] = '0;
    end else begin
      for (int a = 1; a < 32; a++) begin
        v = after_edge({32'h0, m_a[a]}, a, 4, 31);
        m_a[a] = v[31:0];
      end
      for (int a = 0; a < 32; a++) begin
        v = after_edge({32'h0, m_b[a]}, a, 4, 31);
        m_b[a] = v[31:0];
      end
      for (int a = 1; a < 16; a++) m_w[a] = after_edge(m_w[a], a, 8, 15);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set #1 after a rising edge; step() queues this cycle's
  // expectations, waits for the edge, then advances the model.
  task automatic step();
    push_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0;
    wd0 = '0; wd1 = '0; be0 = '0; be1 = '0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [63:0] d, input logic [7:0] be);
    we0 = 1'b1; wa0 = a; wd0 = d; be0 = be;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [63:0] d, input logic [7:0] be);
    we1 = 1'b1; wa1 = a; wd1 = d; be1 = be;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    ra0 = a0; ra1 = a1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1'b1;
    rd(5'd0, 5'd0);
    for (int k = 0; k < 4; k++) rw[k] = 4'd0;
    prev_rst = 1'b0;
    @(posedge clk); #1;

    // Reset held for two cycles.
    push_lit(0, 0, 64'h0, "rst_hold_a");
    step();
    step();

    // Fill every register with ones, two per cycle.
    for (int i = 0; i < 16; i++) begin
      idle();
      wr0(5'(2*i),   64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      wr1(5'(2*i+1), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      step();
    end
    idle(); rd(5'd31, 5'd1);
    push_lit(1, 0, 64'hFFFF_FFFF, "fill_b");
    step();

    // One-cycle reset pulse with reads active: rdata must be zero.
    idle(); rst = 1'b1; rd(5'd31, 5'd1);
    push_lit(0, 0, 64'h0, "rst_cycle_a");
    push_lit(1, 0, 64'h0, "rst_cycle_b");
    step();

    // Read back every register on both ports; all cleared.
    idle();
    for (int i = 0; i < 16; i++) begin
      rd(5'(2*i), 5'(2*i+1));
      push_lit(0, 0, 64'h0, "clr_a0"); push_lit(0, 1, 64'h0, "clr_a1");
      push_lit(1, 0, 64'h0, "clr_b0"); push_lit(1, 1, 64'h0, "clr_b1");
      step();
    end

    // Byte-enable write on reg 5.
    idle(); wr0(5'd5, 64'h1122_3344, 8'h0F); step();
    idle(); wr0(5'd5, 64'hAABB_CCDD, 8'h05); rd(5'd5, 5'd5);
    push_lit(0, 0, 64'h11BB_33DD, "be_bypass");
    push_lit(1, 0, 64'h1122_3344, "be_old");
    step();
    idle(); rd(5'd5, 5'd5);
    push_lit(1, 1, 64'h11BB_33DD, "be_stored");
    step();

    // Dual-port collision on reg 7.
    idle(); wr0(5'd7, 64'h0, 8'hFF); step();
    idle(); wr0(5'd7, 64'hAAAA_AAAA, 8'h0F); wr1(5'd7, 64'h5555_5555, 8'h03); rd(5'd7, 5'd7);
    push_lit(0, 0, 64'hAAAA_5555, "coll_bypass");
    push_lit(1, 0, 64'h0, "coll_old");
    step();
    idle(); rd(5'd7, 5'd7);
    push_lit(1, 0, 64'hAAAA_5555, "coll_stored");
    step();

    // Bypass on reg 3 from port 1.
    idle(); wr0(5'd3, 64'h0, 8'hFF); step();
    idle(); wr1(5'd3, 64'h1234_5678, 8'hFF); rd(5'd3, 5'd3);
    push_lit(0, 0, 64'h1234_5678, "byp_on");
    push_lit(1, 0, 64'h0, "byp_off_pre");
    step();
    idle(); rd(5'd3, 5'd3);
    push_lit(1, 0, 64'h1234_5678, "byp_off_post");
    step();

    // Zero register: both ports write address 0.
    idle(); wr0(5'd0, 64'hDEAD_BEEF, 8'hFF); wr1(5'd0, 64'hDEAD_BEEF, 8'hFF); rd(5'd0, 5'd0);
    push_lit(0, 0, 64'h0, "zero_byp0"); push_lit(0, 1, 64'h0, "zero_byp1");
    step();
    idle(); rd(5'd0, 5'd0);
    push_lit(0, 0, 64'h0, "zero_a");
    push_lit(1, 0, 64'hDEAD_BEEF, "zero_off");
    step();

    // Wide instance sweep: reg i = 0x0101..01 * i.
    for (int i = 0; i < 16; i++) begin
      idle(); wr0(5'(i), 64'h0101_0101_0101_0101 * 64'(i), 8'hFF); step();
    end
    idle();
    rw[0] = 4'd15; rw[1] = 4'd14; rw[2] = 4'd13; rw[3] = 4'd12;
    push_lit(2, 0, 64'h0F0F_0F0F_0F0F_0F0F, "sweep15");
    push_lit(2, 1, 64'h0E0E_0E0E_0E0E_0E0E, "sweep14");
    push_lit(2, 2, 64'h0D0D_0D0D_0D0D_0D0D, "sweep13");
    push_lit(2, 3, 64'h0C0C_0C0C_0C0C_0C0C, "sweep12");
    step();

    // Sweep again with reset landing on i=8 (its write is discarded).
    for (int i = 0; i <= 8; i++) begin
      idle(); wr0(5'(i), 64'h0202_0202_0202_0202 * 64'(i), 8'hFF);
      rst = (i == 8);
      step();
    end
    idle();
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        rw[k] = 4'(4*g + k);
        push_lit(2, k, 64'h0, "sweep_rst");
      end
      step();
    end

    // Randomised traffic; addresses biased low to force collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      if (!prev_rst) begin
        we0 = 1'($urandom_range(0, 1));
        wa0 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        wd0 = {$urandom, $urandom};
        be0 = 8'($urandom_range(0, 255));
        we1 = 1'($urandom_range(0, 1));
        wa1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        wd1 = {$urandom, $urandom};
        be1 = 8'($urandom_range(0, 255));
      end
      ra0 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 1) == 1) ? wa1 : 5'($urandom_range(0, 31));
      for (int k = 0; k < 4; k++)
        rw[k] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 19) == 0);
      prev_rst = rst;
      step();
    end

    // Final report.
    idle();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
